// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, traps on illegal opcodes.
// Per-instruction latency 3-5 cycles plus one per mem_ready=0 cycle in FETCH/MEMRD/MEMWR; stalls in place on mem_ready.
module multicycle_control #(
  parameter int CNT_WIDTH     = 32,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_ADDI  = 1'b1,
  parameter bit SUPPORT_JUMP  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instrWord,
  input  logic                 mem_ready,
  output logic                 RegDest,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PCSource,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JUMP   = 4'd12, TRAP   = 4'd15
  } state_t;

  typedef struct packed {
    logic       regdest;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     st, nxt;
  ctl_t       ctl_q;
  logic [5:0] op_q;
  logic       rdy, retire;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instrWord[25:0];
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  function automatic state_t decode_op(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return EXEC;
      OP_LW, OP_SW: return MEMADR;
      OP_BEQ:       return BRANCH;
      OP_ADDI:      return SUPPORT_ADDI ? ADDIEX : TRAP;
      OP_J:         return SUPPORT_JUMP ? JUMP : TRAP;
      default:      return TRAP;
    endcase
  endfunction

  // Control word for the state being entered; FETCH's IR/PC strobes are gated by mem_ready separately.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; end
      DECODE: c.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:  begin c.regdest = 1'b1; c.regwrite = 1'b1; end
      ADDIWB: c.regwrite = 1'b1;
      BRANCH: begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
      end
      JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      TRAP:   c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = st;
    case (st)
      IDLE:   nxt = FETCH;
      FETCH:  if (rdy) nxt = DECODE;
      DECODE: nxt = decode_op(instrWord[31:26]);
      MEMADR: nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (rdy) nxt = MEMWB;
      MEMWR:  if (rdy) nxt = FETCH;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  assign retire = (st inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP}) || (st == MEMWR && rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      ctl_q       <= '0;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      st    <= nxt;
      ctl_q <= ctl_of(nxt);
      if (st == DECODE) op_q <= instrWord[31:26];
      if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  assign state       = st;
  assign RegDest     = ctl_q.regdest;
  assign RegWrite    = ctl_q.regwrite;
  assign MemToReg    = ctl_q.memtoreg;
  assign ALUSrcA     = ctl_q.alusrca;
  assign ALUSrcB     = ctl_q.alusrcb;
  assign ALUOp       = ctl_q.aluop;
  assign MemRead     = ctl_q.memread;
  assign MemWrite    = ctl_q.memwrite;
  assign IorD        = ctl_q.iord;
  assign IRWrite     = (st == FETCH) && rdy;
  assign PCWrite     = ctl_q.pcwrite | IRWrite;
  assign PCWriteCond = ctl_q.pcwritecond;
  assign PCSource    = ctl_q.pcsource;
  assign illegal     = ctl_q.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default instance plus a variant with
// no handshake, no addi/j and a 4-bit counter, sharing clock and inputs.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrWord;
  logic        mem_ready;

  logic m_RegDest, m_RegWrite, m_MemToReg, m_ALUSrcA, m_MemRead, m_MemWrite, m_IorD;
  logic m_IRWrite, m_PCWrite, m_PCWriteCond, m_illegal;
  logic [1:0] m_ALUSrcB, m_ALUOp, m_PCSource;
  logic [3:0] m_state;
  logic [31:0] m_count;

  logic a_RegDest, a_RegWrite, a_MemToReg, a_ALUSrcA, a_MemRead, a_MemWrite, a_IorD;
  logic a_IRWrite, a_PCWrite, a_PCWriteCond, a_illegal;
  logic [1:0] a_ALUSrcB, a_ALUOp, a_PCSource;
  logic [3:0] a_state;
  logic [3:0] a_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .rst(rst), .instrWord(instrWord), .mem_ready(mem_ready),
    .RegDest(m_RegDest), .RegWrite(m_RegWrite), .MemToReg(m_MemToReg),
    .ALUSrcA(m_ALUSrcA), .ALUSrcB(m_ALUSrcB), .ALUOp(m_ALUOp),
    .MemRead(m_MemRead), .MemWrite(m_MemWrite), .IorD(m_IorD), .IRWrite(m_IRWrite),
    .PCWrite(m_PCWrite), .PCWriteCond(m_PCWriteCond), .PCSource(m_PCSource),
    .illegal(m_illegal), .state(m_state), .instr_count(m_count)
  );

  multicycle_control #(
    .CNT_WIDTH(4), .MEM_HANDSHAKE(1'b0), .SUPPORT_ADDI(1'b0), .SUPPORT_JUMP(1'b0)
  ) u_alt (
    .clk(clk), .rst(rst), .instrWord(instrWord), .mem_ready(mem_ready),
    .RegDest(a_RegDest), .RegWrite(a_RegWrite), .MemToReg(a_MemToReg),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp),
    .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IorD(a_IorD), .IRWrite(a_IRWrite),
    .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .PCSource(a_PCSource),
    .illegal(a_illegal), .state(a_state), .instr_count(a_count)
  );

  // {RegDest RegWrite MemToReg}_ALUSrcA_ALUSrcB_ALUOp_{MemRead MemWrite IorD}_{IRWrite PCWrite PCWriteCond}_PCSource_illegal
  logic [16:0] m_ctl, a_ctl;
  assign m_ctl = {m_RegDest, m_RegWrite, m_MemToReg, m_ALUSrcA, m_ALUSrcB, m_ALUOp,
                  m_MemRead, m_MemWrite, m_IorD, m_IRWrite, m_PCWrite, m_PCWriteCond,
                  m_PCSource, m_illegal};
  assign a_ctl = {a_RegDest, a_RegWrite, a_MemToReg, a_ALUSrcA, a_ALUSrcB, a_ALUOp,
                  a_MemRead, a_MemWrite, a_IorD, a_IRWrite, a_PCWrite, a_PCWriteCond,
                  a_PCSource, a_illegal};

  localparam logic [16:0] C_NONE   = 17'b000_0_00_00_000_000_00_0;
  localparam logic [16:0] C_FETCH  = 17'b000_0_01_00_100_110_00_0;
  localparam logic [16:0] C_FETCHW = 17'b000_0_01_00_100_000_00_0;
  localparam logic [16:0] C_DECODE = 17'b000_0_11_00_000_000_00_0;
  localparam logic [16:0] C_MEMADR = 17'b000_1_10_00_000_000_00_0;
  localparam logic [16:0] C_MEMRD  = 17'b000_0_00_00_101_000_00_0;
  localparam logic [16:0] C_MEMWR  = 17'b000_0_00_00_011_000_00_0;
  localparam logic [16:0] C_MEMWB  = 17'b011_0_00_00_000_000_00_0;
  localparam logic [16:0] C_EXEC   = 17'b000_1_00_10_000_000_00_0;
  localparam logic [16:0] C_ALUWB  = 17'b110_0_00_00_000_000_00_0;
  localparam logic [16:0] C_ADDIWB = 17'b010_0_00_00_000_000_00_0;
  localparam logic [16:0] C_BRANCH = 17'b000_1_00_01_000_001_01_0;
  localparam logic [16:0] C_JUMP   = 17'b000_0_00_00_000_010_10_0;
  localparam logic [16:0] C_TRAP   = 17'b000_0_00_00_000_000_00_1;

  localparam logic [31:0] I_RTYPE = 32'h012A4020;
  localparam logic [31:0] I_LW    = 32'h8D090004;
  localparam logic [31:0] I_SW    = 32'hAD090004;
  localparam logic [31:0] I_BEQ   = 32'h11090004;
  localparam logic [31:0] I_ADDI  = 32'h21280005;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_BAD   = 32'hFC000000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in FETCH with counters cleared.
  task automatic restart;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_ready = 1'b1; instrWord = 32'h0;
    tick();
    checks++; if (m_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", m_state); end
    checks++; if (m_ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", m_ctl, C_NONE); end
    checks++; if (m_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", m_count); end
    checks++; if (a_state !== 4'd0 || a_ctl !== C_NONE) begin errors++; $display("FAIL reset_alt: got state %0d ctl %b expected 0 / %b", a_state, a_ctl, C_NONE); end
  endtask

  task automatic test_rtype;
    logic [3:0]  sts [5];
    logic [16:0] cs  [5];
    sts = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
    cs  = '{C_FETCH, C_DECODE, C_EXEC, C_ALUWB, C_FETCH};
    rst = 1'b1; mem_ready = 1'b1; instrWord = I_RTYPE;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (m_state !== 4'd0) begin errors++; $display("FAIL rtype_idle: got %0d expected 0", m_state); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m_state !== sts[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, m_state, sts[i]); end
      checks++; if (m_ctl !== cs[i]) begin errors++; $display("FAIL rtype_ctl[%0d]: got %b expected %b", i, m_ctl, cs[i]); end
      if (i == 3) begin
        checks++; if (m_count !== 32'd0) begin errors++; $display("FAIL rtype_count_pre: got %0d expected 0", m_count); end
      end
    end
    checks++; if (m_count !== 32'd1) begin errors++; $display("FAIL rtype_count: got %0d expected 1", m_count); end
  endtask

  // Continues from FETCH with one instruction already retired.
  task automatic test_lw_stall;
    instrWord = I_LW; mem_ready = 1'b1;
    tick();
    tick();
    checks++; if (m_state !== 4'd3 || m_ctl !== C_MEMADR) begin errors++; $display("FAIL lw_memadr: got state %0d ctl %b expected 3 / %b", m_state, m_ctl, C_MEMADR); end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m_state !== 4'd4) begin errors++; $display("FAIL lw_memrd_state[%0d]: got %0d expected 4", i, m_state); end
      checks++; if (m_ctl !== C_MEMRD) begin errors++; $display("FAIL lw_memrd_ctl[%0d]: got %b expected %b", i, m_ctl, C_MEMRD); end
      if (i == 3) mem_ready = 1'b1;
    end
    tick();
    checks++; if (m_state !== 4'd5 || m_ctl !== C_MEMWB) begin errors++; $display("FAIL lw_memwb: got state %0d ctl %b expected 5 / %b", m_state, m_ctl, C_MEMWB); end
    checks++; if (m_count !== 32'd1) begin errors++; $display("FAIL lw_count_pre: got %0d expected 1", m_count); end
    tick();
    checks++; if (m_state !== 4'd1 || m_count !== 32'd2) begin errors++; $display("FAIL lw_retire: got state %0d count %0d expected 1 / 2", m_state, m_count); end
  endtask

  task automatic test_sw_beq_j;
    mem_ready = 1'b1;
    restart();
    instrWord = I_SW;
    tick();
    tick();
    instrWord = I_LW;
    tick();
    checks++; if (m_state !== 4'd6) begin errors++; $display("FAIL sw_state: got %0d expected 6", m_state); end
    checks++; if (m_ctl !== C_MEMWR) begin errors++; $display("FAIL sw_ctl: got %b expected %b", m_ctl, C_MEMWR); end
    instrWord = I_BEQ;
    tick();
    checks++; if (m_state !== 4'd1 || m_count !== 32'd1) begin errors++; $display("FAIL sw_retire: got state %0d count %0d expected 1 / 1", m_state, m_count); end
    tick();
    tick();
    checks++; if (m_state !== 4'd9 || m_ctl !== C_BRANCH) begin errors++; $display("FAIL beq: got state %0d ctl %b expected 9 / %b", m_state, m_ctl, C_BRANCH); end
    instrWord = I_J;
    tick();
    checks++; if (m_count !== 32'd2) begin errors++; $display("FAIL beq_count: got %0d expected 2", m_count); end
    tick();
    tick();
    checks++; if (m_state !== 4'd12 || m_ctl !== C_JUMP) begin errors++; $display("FAIL jump: got state %0d ctl %b expected 12 / %b", m_state, m_ctl, C_JUMP); end
    checks++; if (a_state !== 4'd15 || a_ctl !== C_TRAP) begin errors++; $display("FAIL alt_j_trap: got state %0d ctl %b expected 15 / %b", a_state, a_ctl, C_TRAP); end
    checks++; if (a_count !== 4'd2) begin errors++; $display("FAIL alt_trap_count: got %0d expected 2", a_count); end
    tick();
    checks++; if (m_state !== 4'd1 || m_count !== 32'd3) begin errors++; $display("FAIL sbj_count: got state %0d count %0d expected 1 / 3", m_state, m_count); end
  endtask

  task automatic test_addi;
    mem_ready = 1'b1;
    restart();
    instrWord = I_ADDI;
    tick();
    tick();
    checks++; if (m_state !== 4'd10 || m_ctl !== C_MEMADR) begin errors++; $display("FAIL addiex: got state %0d ctl %b expected 10 / %b", m_state, m_ctl, C_MEMADR); end
    checks++; if (a_state !== 4'd15) begin errors++; $display("FAIL alt_addi_trap: got %0d expected 15", a_state); end
    tick();
    checks++; if (m_state !== 4'd11 || m_ctl !== C_ADDIWB) begin errors++; $display("FAIL addiwb: got state %0d ctl %b expected 11 / %b", m_state, m_ctl, C_ADDIWB); end
    tick();
    checks++; if (m_state !== 4'd1 || m_count !== 32'd1) begin errors++; $display("FAIL addi_retire: got state %0d count %0d expected 1 / 1", m_state, m_count); end
  endtask

  task automatic test_trap;
    mem_ready = 1'b1;
    restart();
    instrWord = I_RTYPE;
    tick();
    tick();
    instrWord = I_BAD;
    tick();
    tick();
    tick();
    tick();
    checks++; if (m_state !== 4'd15 || m_ctl !== C_TRAP) begin errors++; $display("FAIL trap_enter: got state %0d ctl %b expected 15 / %b", m_state, m_ctl, C_TRAP); end
    checks++; if (m_count !== 32'd1) begin errors++; $display("FAIL trap_count: got %0d expected 1", m_count); end
    instrWord = I_RTYPE;
    for (int i = 0; i < 6; i++) begin
      mem_ready = i[0];
      tick();
    end
    checks++; if (m_state !== 4'd15 || m_illegal !== 1'b1 || m_count !== 32'd1) begin errors++; $display("FAIL trap_hold: got state %0d illegal %b count %0d expected 15 / 1 / 1", m_state, m_illegal, m_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m_state !== 4'd0 || m_count !== 32'd0 || m_ctl !== C_NONE) begin errors++; $display("FAIL trap_reset: got state %0d count %0d ctl %b expected 0 / 0 / 0", m_state, m_count, m_ctl); end
  endtask

  task automatic test_reset_midinstr;
    mem_ready = 1'b1;
    restart();
    instrWord = I_LW;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    checks++; if (m_state !== 4'd4) begin errors++; $display("FAIL mid_memrd: got %0d expected 4", m_state); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (m_state !== 4'd0 || m_ctl !== C_NONE) begin errors++; $display("FAIL mid_async_clear: got state %0d ctl %b expected 0 / 0", m_state, m_ctl); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (m_state !== 4'd0) begin errors++; $display("FAIL mid_idle: got %0d expected 0", m_state); end
    tick();
    checks++; if (m_state !== 4'd1 || m_ctl !== C_FETCHW) begin errors++; $display("FAIL mid_fetch_wait: got state %0d ctl %b expected 1 / %b", m_state, m_ctl, C_FETCHW); end
    mem_ready = 1'b1;
    #1;
    checks++; if (m_ctl !== C_FETCH) begin errors++; $display("FAIL mid_fetch_ready: got %b expected %b", m_ctl, C_FETCH); end
  endtask

  // The variant ignores mem_ready, so it retires while the default instance stalls in FETCH.
  task automatic test_wrap;
    mem_ready = 1'b1;
    restart();
    mem_ready = 1'b0;
    instrWord = I_RTYPE;
    #1;
    checks++; if (a_ctl !== C_FETCH) begin errors++; $display("FAIL alt_fetch_nohs: got %b expected %b", a_ctl, C_FETCH); end
    for (int n = 1; n <= 17; n++) begin
      for (int c = 0; c < 4; c++) tick();
      if (n == 15) begin
        checks++; if (a_count !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d expected 15", a_count); end
      end
      if (n == 16) begin
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d expected 0", a_count); end
      end
    end
    checks++; if (a_count !== 4'd1 || a_state !== 4'd1) begin errors++; $display("FAIL wrap_17: got count %0d state %0d expected 1 / 1", a_count, a_state); end
    checks++; if (m_state !== 4'd1 || m_count !== 32'd0) begin errors++; $display("FAIL fetch_stall: got state %0d count %0d expected 1 / 0", m_state, m_count); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_beq_j();
    test_addi();
    test_trap();
    test_reset_midinstr();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
